serial_adder_ctrl: RTL

Bit-serial N-bit adder controller. It sequences a single full-adder cell, built from two `halfadder` instances plus an OR for carry-out, across WIDTH cycles. Operands are latched, added LSB-first one bit per clock, and the result is reported with a start/busy/done handshake. It is the first clocked block in the combinational-circuits series and reuses the existing half adder as its only arithmetic datapath.

---
 rtl/serial_adder_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: latches two WIDTH-bit operands and adds them
// LSB-first, one bit per clock, through a single full-adder cell built from
// two half adders. Start/busy/done handshake: a request is accepted only
// when the block is idle and start is high on a rising edge. busy is high
// while bits are being processed. done pulses for one cycle when SUM/COUT
// hold the final result. start is ignored while busy or done (no queuing).

// Half adder: the only arithmetic primitive in the datapath.
module halfadder (
  input  logic X,
  input  logic Y,
  output logic S,
  output logic C
);
  assign S = X ^ Y;
  assign C = X & Y;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_count;

  logic             w_ha0_s;
  logic             w_ha0_c;
  logic             w_ha1_s;
  logic             w_ha1_c;
  logic             w_carry_next;
  logic             w_last_bit;
  logic             w_accept;
  logic [WIDTH-1:0] w_sum_shift;

  // Full-adder cell: HA0 adds the two operand LSBs, HA1 folds in the carry.
  halfadder u_ha0 (
    .X (r_a[0]),
    .Y (r_b[0]),
    .S (w_ha0_s),
    .C (w_ha0_c)
  );

  halfadder u_ha1 (
    .X (w_ha0_s),
    .Y (r_carry),
    .S (w_ha1_s),
    .C (w_ha1_c)
  );

  assign w_carry_next = w_ha0_c | w_ha1_c;
  assign w_last_bit   = (r_count == CW'(WIDTH - 1));

  // New sum bit enters at the MSB; written this way so WIDTH=1 needs no special case.
  always_comb begin
    w_sum_shift            = r_sum >> 1;
    w_sum_shift[WIDTH-1]   = w_ha1_s;
  end

  // Next-state decode: accept in IDLE, leave SHIFT after the last bit, DONE lasts one cycle.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last_bit) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Datapath registers: load on accept, shift one bit per SHIFT cycle, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= B;
      r_carry <= 1'b0;
      r_count <= '0;
    end else if (r_state == S_SHIFT) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_sum   <= w_sum_shift;
      r_carry <= w_carry_next;
      r_count <= r_count + CW'(1);
    end
  end

  // Outputs come straight from registers and state decode only.
  assign busy = (r_state == S_SHIFT);
  assign done = (r_state == S_DONE);
  assign SUM  = r_sum;
  assign COUT = r_carry;

endmodule
